// File: rtl/writeback_cycle.sv
// MEM/WB pipeline register and write-back stage of the RV32I core.
// Holds the memory-stage outputs for one cycle, then extracts the load
// data, picks the register-file write value and qualifies the write enable.
module writeback_cycle #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [XLEN-1:0]  ReadDataM,
  input  logic [XLEN-1:0]  ALUResultM,
  input  logic [XLEN-1:0]  PCPlus4M,
  input  logic [4:0]       RdM,
  input  logic             RegWriteM,
  input  logic [1:0]       ResultSrcM,
  input  logic [2:0]       Funct3M,
  input  logic             ValidM,
  input  logic             StallW,
  input  logic             FlushW,
  output logic [XLEN-1:0]  ResultW,
  output logic [4:0]       RdW,
  output logic             RegWriteW,
  output logic             ValidW,
  output logic             MisalignW,
  output logic [CNT_W-1:0] InstRetW
);

  localparam logic [1:0] SRC_LOAD = 2'b01;
  localparam logic [1:0] SRC_PC4  = 2'b10;

  // Selects the byte/half/word addressed by off and extends it by funct3.
  // Halfword selection only looks at off[1]; odd offsets are flagged as
  // misaligned elsewhere but still produce a deterministic value here.
  function automatic logic [XLEN-1:0] extract_load(input logic [XLEN-1:0] word,
                                                   input logic [2:0]      f3,
                                                   input logic [1:0]      off);
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    sb = word[{off, 3'b000} +: 8];
    sh = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  return {{(XLEN-8){sb[7]}}, sb};
      3'b100:  return {{(XLEN-8){1'b0}}, sb};
      3'b001:  return {{(XLEN-16){sh[15]}}, sh};
      3'b101:  return {{(XLEN-16){1'b0}}, sh};
      default: return word;
    endcase
  endfunction

  // Halfwords need an even offset; words (and undefined encodings, which
  // behave as LW) need offset 0; bytes are always aligned.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      3'b000, 3'b100: return 1'b0;
      3'b001, 3'b101: return off[0];
      default:        return off != 2'b00;
    endcase
  endfunction

  logic [XLEN-1:0]  read_data_p1;
  logic [XLEN-1:0]  alu_result_p1;
  logic [XLEN-1:0]  pc_plus4_p1;
  logic [4:0]       rd_p1;
  logic             reg_write_p1;
  logic [1:0]       result_src_p1;
  logic [2:0]       funct3_p1;
  logic             vld_p1;
  logic [CNT_W-1:0] inst_ret_p1;
  logic             mis_p1;

  // ---- M -> W boundary ----
  // W register: flush clears to a bubble, stall holds, otherwise capture M.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      read_data_p1  <= '0;
      alu_result_p1 <= '0;
      pc_plus4_p1   <= '0;
      rd_p1         <= '0;
      reg_write_p1  <= 1'b0;
      result_src_p1 <= 2'b00;
      funct3_p1     <= 3'b000;
      vld_p1        <= 1'b0;
    end else if (FlushW) begin
      read_data_p1  <= '0;
      alu_result_p1 <= '0;
      pc_plus4_p1   <= '0;
      rd_p1         <= '0;
      reg_write_p1  <= 1'b0;
      result_src_p1 <= 2'b00;
      funct3_p1     <= 3'b000;
      vld_p1        <= 1'b0;
    end else if (!StallW) begin
      read_data_p1  <= ReadDataM;
      alu_result_p1 <= ALUResultM;
      pc_plus4_p1   <= PCPlus4M;
      rd_p1         <= RdM;
      reg_write_p1  <= RegWriteM;
      result_src_p1 <= ResultSrcM;
      funct3_p1     <= Funct3M;
      vld_p1        <= ValidM;
    end
  end

  // Retired-instruction counter: counts every valid capture, wraps silently.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      inst_ret_p1 <= '0;
    else if (ValidM && !StallW && !FlushW)
      inst_ret_p1 <= inst_ret_p1 + CNT_W'(1);
  end

  // ---- W stage (combinational from W registers only) ----
  // Result mux, misalignment detect and write-enable qualification.
  always_comb begin
    mis_p1 = vld_p1 && (result_src_p1 == SRC_LOAD) &&
             misaligned(funct3_p1, alu_result_p1[1:0]);
    case (result_src_p1)
      SRC_LOAD: ResultW = extract_load(read_data_p1, funct3_p1, alu_result_p1[1:0]);
      SRC_PC4:  ResultW = pc_plus4_p1;
      default:  ResultW = alu_result_p1;
    endcase
  end

  assign RdW       = rd_p1;
  assign ValidW    = vld_p1;
  assign MisalignW = mis_p1;
  assign RegWriteW = reg_write_p1 && vld_p1 && (rd_p1 != 5'd0) && !mis_p1;
  assign InstRetW  = inst_ret_p1;

endmodule

// File: doc/writeback_cycle.md
Name: writeback_cycle

Overview:
- MEM/WB pipeline register plus the write-back stage of the 5-stage RV32I core; sits directly downstream of the memory stage.
- Captures the memory stage outputs and extracts and sign/zero-extends load data by funct3 and byte offset.
- Selects the register-file write value and suppresses writes for bubbles, x0 and misaligned loads.
- Supports stall/flush and keeps a retired-instruction counter.

Parameters:
- XLEN, 32, datapath width.
- CNT_W, 64, width of the retired-instruction counter.

Ports:
- clk  input  1  core clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- ReadDataM  input  XLEN  raw 32-bit word from data memory (word-aligned read).
- ALUResultM  input  XLEN  ALU result / effective address.
- PCPlus4M  input  XLEN  PC+4 of the instruction in MEM.
- RdM  input  5  destination register.
- RegWriteM  input  1  instruction writes rd.
- ResultSrcM  input  2  00 ALU, 01 load, 10 PC+4, 11 treated as ALU.
- Funct3M  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- ValidM  input  1  MEM slot holds a real instruction.
- StallW  input  1  hold the W register.
- FlushW  input  1  insert a bubble into W.
- ResultW  output  XLEN  write-back value to the register file and forwarding unit.
- RdW  output  5  registered destination register.
- RegWriteW  output  1  register-file write enable (qualified).
- ValidW  output  1  W slot holds a real instruction.
- MisalignW  output  1  W holds a misaligned load.
- InstRetW  output  CNT_W  retired-instruction count.

Behaviour:
- Reset (reset=0, async):
  - All W registers clear: data fields 0, RdW=0, ValidW=0, ResultSrc=00.
  - ResultW=0, RegWriteW=0, MisalignW=0, InstRetW=0.
- Capture rule per rising edge, priority FlushW > StallW > load:
  - FlushW=1: ValidW<=0 and registered RegWrite<=0; other fields are don't-care but must be deterministic (clear to 0).
  - StallW=1 (no flush): all W registers hold.
  - Otherwise: capture all M inputs, including ALUResultM[1:0] as the byte offset.
- Latency: exactly 1 cycle M->W; ResultW is combinational from W registers only, never from M inputs.
- Load extraction (ResultSrc=01), byte offset off=ALUResult[1:0]:
  - LB/LBU: byte ReadData[8*off+7:8*off], sign/zero-extended.
  - LH/LHU: off=0 -> bits 15:0; off=2 -> bits 31:16; sign/zero-extended.
  - LW: the full word.
  - Undefined funct3 (011, 110, 111): behaves as LW.
- Misalignment:
  - Condition: load with LH/LHU and off[0]=1, or LW and off!=0.
  - MisalignW=1 when ValidW=1 and the condition holds.
  - ResultW is still the extracted value per the rules above; only the write is suppressed.
- RegWriteW = registered RegWrite & ValidW & (RdW!=0) & ~MisalignW. Writes to x0 never reach the register file.
- Result mux: 00/11 -> ALUResult; 01 -> extracted load; 10 -> PCPlus4.
- InstRetW:
  - Increments by 1 on each edge where a valid instruction is captured (ValidM=1, StallW=0, FlushW=0).
  - A misaligned load still counts as retired.
  - Wraps modulo 2^CNT_W without any flag.
- Stall and flush both high: flush wins, and the counter does not increment.
- Reset asserted mid-stall or mid-flush: immediate clear; the first edge after deassertion captures normally.

Test Plan:
- Reset: hold reset=0 with arbitrary inputs -> all outputs 0. Release reset, then one edge with ValidM=1, RegWriteM=1, RdM=5, ResultSrcM=00, ALUResultM=0x1234 -> ResultW=0x1234, RdW=5, RegWriteW=1, InstRetW=1.
- Load extraction with ReadDataM=0x80FF7F01:
  - LB off=3 -> 0xFFFFFF80
  - LBU off=1 -> 0x0000007F
  - LH off=2 -> 0xFFFF80FF
  - LHU off=0 -> 0x00007F01
  - LW off=0 -> 0x80FF7F01
- Misalign: LH at address 0x1001 -> MisalignW=1, RegWriteW=0, ValidW=1, InstRetW increments. LW at 0x1002 -> same response.
- Stall/flush:
  - StallW=1 for 3 cycles while M inputs change -> W outputs constant and InstRetW constant.
  - FlushW=1 together with StallW=1 -> ValidW=0, RegWriteW=0, no count.
- Mux and x0:
  - ResultSrcM=10, PCPlus4M=0x0000_0104 -> ResultW=0x104.
  - RdM=0 with RegWriteM=1 -> RegWriteW=0, ValidW=1.
- Wrap: with CNT_W=4, 17 valid captures -> InstRetW=1. Assert reset asynchronously mid-clock -> InstRetW=0 immediately, before the next edge.
